// File: rtl/stw_pkg.sv
// Shared definitions for the STW self-test controller: FSM encoding, vector
// tuple type and the fixed MAC test vectors broadcast to every PE.
package stw_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_IDX_W   = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] add;
    logic [15:0] expected;
  } stw_vec_t;

  // expected = (op1*op2 + add) mod 2^16
  localparam stw_vec_t V0 = '{op1: 16'h0003, op2: 16'h0005, add: 16'h0007, expected: 16'h0016};
  localparam stw_vec_t V1 = '{op1: 16'h00FF, op2: 16'h0101, add: 16'h0001, expected: 16'h0000};
  localparam stw_vec_t V2 = '{op1: 16'h5555, op2: 16'h0002, add: 16'hAAAA, expected: 16'h5554};
  localparam stw_vec_t V3 = '{op1: 16'h0000, op2: 16'h1234, add: 16'h8000, expected: 16'h8000};

endpackage

// File: rtl/stw_controller_if.sv
// STW bus between the array-level controller (master) and the PEs (slave).
interface stw_controller_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 16
);
  logic                 STW_test_load_en;
  logic [WORD_SIZE-1:0] STW_mult_op1;
  logic [WORD_SIZE-1:0] STW_mult_op2;
  logic [WORD_SIZE-1:0] STW_add_op;
  logic [WORD_SIZE-1:0] STW_expected;
  logic                 STW_start;
  logic [NUM_PE-1:0]    STW_complete;
  logic [NUM_PE-1:0]    STW_result_out;

  modport master (
    output STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    input  STW_complete, STW_result_out
  );

  modport slave (
    input  STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, STW_start,
    output STW_complete, STW_result_out
  );
endinterface

// File: rtl/stw_vector_rom.sv
// Combinational lookup of a vector index to its {op1, op2, add, expected} tuple.
module stw_vector_rom
  import stw_pkg::*;
(
  input  logic [VEC_IDX_W-1:0] i_idx,
  output stw_vec_t             o_vec
);

  always_comb begin
    o_vec = V0;
    case (i_idx)
      2'd0:    o_vec = V0;
      2'd1:    o_vec = V1;
      2'd2:    o_vec = V2;
      2'd3:    o_vec = V3;
      default: o_vec = V0;
    endcase
  end

endmodule

// File: rtl/stw_controller.sv
// Array-level STW initiator: broadcasts test vectors, collects per-PE results
// and publishes a sticky fault map. Optional periodic retest: STW_PERIODIC_EN.
module stw_controller
  import stw_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PE      = 16,
  parameter int TIMEOUT     = 64,
  parameter int TEST_PERIOD = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_req,
  output logic              test_busy,
  output logic              test_done,
  output logic [NUM_PE-1:0] fault_map,
  output logic              map_valid,
  stw_controller_if.master  stw
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [VEC_IDX_W-1:0] r_vec_idx;
  logic [VEC_IDX_W-1:0] w_vec_idx_nxt;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic [NUM_PE-1:0]    r_fail_acc;
  logic [NUM_PE-1:0]    r_fault_map;
  logic                 r_map_valid;
  logic [WORD_SIZE-1:0] r_op1, r_op2, r_add, r_exp;
  logic                 w_req;
  stw_vec_t             w_vec;

`ifdef STW_PERIODIC_EN
  localparam int             PER_W    = $clog2(TEST_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(TEST_PERIOD - 1);
  logic [PER_W-1:0] r_idle_cnt;

  // Internal and external requests in the same cycle merge into one launch.
  assign w_req = test_req | (r_idle_cnt == PER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_idle_cnt <= '0;
    else if (r_state == S_IDLE && w_state_nxt == S_IDLE) r_idle_cnt <= r_idle_cnt + 1'b1;
    else                                              r_idle_cnt <= '0;
  end
`else
  assign w_req = test_req;
`endif

  // Operands are looked up for the index the FSM will hold in LOAD.
  stw_vector_rom u_rom (
    .i_idx (w_vec_idx_nxt),
    .o_vec (w_vec)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_vec_idx_nxt = r_vec_idx;
    case (r_state)
      S_IDLE: if (w_req) begin
        w_state_nxt   = S_LOAD;
        w_vec_idx_nxt = '0;
      end
      S_LOAD: w_state_nxt = S_ARM;
      S_ARM:  w_state_nxt = S_WAIT;
      // First WAIT cycle is skipped: PEs only drop complete after start.
      S_WAIT: if ((r_wait_cnt != '0 && (&stw.STW_complete)) || r_wait_cnt == CNT_LAST)
        w_state_nxt = S_CHECK;
      S_CHECK: if (r_vec_idx == VEC_IDX_W'(NUM_VECTORS - 1)) begin
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt   = S_LOAD;
        w_vec_idx_nxt = r_vec_idx + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_vec_idx   <= '0;
      r_wait_cnt  <= '0;
      r_fail_acc  <= '0;
      r_fault_map <= '0;
      r_map_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_add       <= '0;
      r_exp       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_vec_idx <= w_vec_idx_nxt;
      if (r_state == S_IDLE && w_req) begin
        r_fail_acc <= '0;
        if (test_req) r_map_valid <= 1'b0;
      end
      if (r_state == S_ARM)  r_wait_cnt <= '0;
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      // A PE that never completed counts as failed.
      if (r_state == S_CHECK)
        r_fail_acc <= r_fail_acc | ~(stw.STW_complete & stw.STW_result_out);
      if (r_state == S_DONE) begin
        r_fault_map <= r_fail_acc;
        r_map_valid <= 1'b1;
      end
      if (w_state_nxt == S_LOAD) begin
        r_op1 <= WORD_SIZE'(w_vec.op1);
        r_op2 <= WORD_SIZE'(w_vec.op2);
        r_add <= WORD_SIZE'(w_vec.add);
        r_exp <= WORD_SIZE'(w_vec.expected);
      end
    end
  end

  assign test_busy            = (r_state != S_IDLE);
  assign test_done            = (r_state == S_DONE);
  assign fault_map            = r_fault_map;
  assign map_valid            = r_map_valid;
  assign stw.STW_test_load_en = (r_state == S_LOAD);
  assign stw.STW_start        = (r_state == S_ARM);
  assign stw.STW_mult_op1     = r_op1;
  assign stw.STW_mult_op2     = r_op2;
  assign stw.STW_add_op       = r_add;
  assign stw.STW_expected     = r_exp;

endmodule

// File: tb/tb_stw_controller.sv
// Directed bench for stw_controller with a per-PE complete/result responder.
module tb_stw_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        test_req = 1'b0;
  logic        test_busy, test_done, map_valid;
  logic [15:0] fault_map;

  stw_controller_if #(.WORD_SIZE(16), .NUM_PE(16)) bus ();

  stw_controller #(.WORD_SIZE(16), .NUM_PE(16), .TIMEOUT(64), .TEST_PERIOD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .test_req  (test_req),
    .test_busy (test_busy),
    .test_done (test_done),
    .fault_map (fault_map),
    .map_valid (map_valid),
    .stw       (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Responder: complete drops the cycle after start, then returns (unless dead).
  logic [15:0] dead_mask = 16'h0000;
  logic        pe5_fail_v2 = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.STW_complete   <= 16'hFFFF;
      bus.STW_result_out <= 16'hFFFF;
    end else begin
      bus.STW_complete   <= bus.STW_start ? 16'h0000 : ~dead_mask;
      bus.STW_result_out <= (pe5_fail_v2 && bus.STW_expected == 16'h5554) ? 16'hFFDF : 16'hFFFF;
    end
  end

  // Observations gathered by run_test; compared by each scenario task.
  int          n_load, n_start, n_done, done_cycle, busy_first;
  logic [15:0] cap_op1 [8];
  logic [15:0] cap_op2 [8];
  logic [15:0] cap_add [8];
  logic [15:0] cap_exp [8];

  task automatic run_test(input int max_cyc, input int pulse_a, input int pulse_b);
    n_load = 0; n_start = 0; n_done = 0; done_cycle = -1; busy_first = 0;
    @(negedge clk); test_req = 1'b1;
    @(negedge clk); test_req = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == 1) busy_first = int'(test_busy);
      test_req = (c == pulse_a || c == pulse_b);
      if (bus.STW_test_load_en) begin
        if (n_load < 8) begin
          cap_op1[n_load] = bus.STW_mult_op1;
          cap_op2[n_load] = bus.STW_mult_op2;
          cap_add[n_load] = bus.STW_add_op;
          cap_exp[n_load] = bus.STW_expected;
        end
        n_load++;
      end
      if (bus.STW_start) n_start++;
      if (test_done) begin
        n_done++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 8) break;
      @(negedge clk);
    end
    test_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (test_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", test_busy); end
    n_vec++; if (test_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", test_done); end
    n_vec++; if (fault_map !== 16'h0) begin n_err++; $display("FAIL reset_map got %h want 0000", fault_map); end
    n_vec++; if (map_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", map_valid); end
    n_vec++; if ({bus.STW_test_load_en, bus.STW_start} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {bus.STW_test_load_en, bus.STW_start}); end
    n_vec++; if ({bus.STW_mult_op1, bus.STW_mult_op2, bus.STW_add_op, bus.STW_expected} !== 64'h0) begin
      n_err++; $display("FAIL reset_buses got %h want 0", {bus.STW_mult_op1, bus.STW_mult_op2, bus.STW_add_op, bus.STW_expected});
    end
    rst = 1'b1;
  endtask

  task automatic test_all_pass();
    run_test(100, 0, 0);
    n_vec++; if (busy_first !== 1) begin n_err++; $display("FAIL pass_busy got %0d want 1", busy_first); end
    n_vec++; if (n_load !== 4 || n_start !== 4) begin n_err++; $display("FAIL pass_pulses got load=%0d start=%0d want 4/4", n_load, n_start); end
    n_vec++; if ({cap_op1[0], cap_op2[0], cap_add[0], cap_exp[0]} !== 64'h0003_0005_0007_0016) begin
      n_err++; $display("FAIL pass_v0 got %h want 0003000500070016", {cap_op1[0], cap_op2[0], cap_add[0], cap_exp[0]});
    end
    n_vec++; if ({cap_op1[1], cap_exp[1], cap_exp[2], cap_exp[3]} !== 64'h00FF_0000_5554_8000) begin
      n_err++; $display("FAIL pass_seq got %h want 00ff000055548000", {cap_op1[1], cap_exp[1], cap_exp[2], cap_exp[3]});
    end
    n_vec++; if (done_cycle !== 21 || n_done !== 1) begin n_err++; $display("FAIL pass_latency got %0d (n=%0d) want 21 (n=1)", done_cycle, n_done); end
    n_vec++; if (fault_map !== 16'h0000 || map_valid !== 1'b1) begin n_err++; $display("FAIL pass_map got %h/%b want 0000/1", fault_map, map_valid); end
    n_vec++; if (test_busy !== 1'b0) begin n_err++; $display("FAIL pass_idle got %b want 0", test_busy); end
  endtask

  task automatic test_pe5_v2();
    pe5_fail_v2 = 1'b1;
    run_test(100, 0, 0);
    pe5_fail_v2 = 1'b0;
    n_vec++; if (fault_map !== 16'h0020 || map_valid !== 1'b1) begin n_err++; $display("FAIL pe5_map got %h/%b want 0020/1", fault_map, map_valid); end
    n_vec++; if (n_load !== 4 || done_cycle !== 21) begin n_err++; $display("FAIL pe5_flow got load=%0d done=%0d want 4/21", n_load, done_cycle); end
  endtask

  task automatic test_timeout();
    dead_mask = 16'h0001;
    run_test(400, 0, 0);
    dead_mask = 16'h0000;
    n_vec++; if (done_cycle !== 4*(64+3)+1) begin n_err++; $display("FAIL tmo_latency got %0d want %0d", done_cycle, 4*(64+3)+1); end
    n_vec++; if (fault_map !== 16'h0001) begin n_err++; $display("FAIL tmo_map got %h want 0001", fault_map); end
    n_vec++; if (n_load !== 4 || n_start !== 4) begin n_err++; $display("FAIL tmo_pulses got %0d/%0d want 4/4", n_load, n_start); end
  endtask

  task automatic test_back_to_back();
    run_test(100, 3, 14);
    n_vec++; if (n_done !== 1 || done_cycle !== 21) begin n_err++; $display("FAIL b2b_done got n=%0d at %0d want 1 at 21", n_done, done_cycle); end
    n_vec++; if (n_load !== 4) begin n_err++; $display("FAIL b2b_loads got %0d want 4", n_load); end
    n_vec++; if ({cap_exp[0], cap_exp[1], cap_exp[2], cap_exp[3]} !== 64'h0016_0000_5554_8000) begin
      n_err++; $display("FAIL b2b_seq got %h want 0016000055548000", {cap_exp[0], cap_exp[1], cap_exp[2], cap_exp[3]});
    end
  endtask

  task automatic test_reset_midtest();
    @(negedge clk); test_req = 1'b1;
    @(negedge clk); test_req = 1'b0;
    repeat (7) @(negedge clk);
    n_vec++; if (test_busy !== 1'b1 || bus.STW_mult_op1 !== 16'h00FF) begin
      n_err++; $display("FAIL mid_pre got busy=%b op1=%h want 1/00ff", test_busy, bus.STW_mult_op1);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({test_busy, test_done, map_valid, bus.STW_test_load_en, bus.STW_start} !== 5'b0) begin
      n_err++; $display("FAIL mid_ctrl got %b want 00000", {test_busy, test_done, map_valid, bus.STW_test_load_en, bus.STW_start});
    end
    n_vec++; if ({fault_map, bus.STW_mult_op1, bus.STW_expected} !== 48'h0) begin
      n_err++; $display("FAIL mid_data got %h want 0", {fault_map, bus.STW_mult_op1, bus.STW_expected});
    end
    @(negedge clk); rst = 1'b1;
    run_test(100, 0, 0);
    n_vec++; if (cap_op1[0] !== 16'h0003 || done_cycle !== 21) begin
      n_err++; $display("FAIL mid_rerun got op1=%h done=%0d want 0003/21", cap_op1[0], done_cycle);
    end
    n_vec++; if (fault_map !== 16'h0000 || map_valid !== 1'b1) begin n_err++; $display("FAIL mid_map got %h/%b want 0000/1", fault_map, map_valid); end
  endtask

`ifdef STW_PERIODIC_EN
  task automatic test_periodic();
    int c;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (test_busy !== 1'b0) begin n_err++; $display("FAIL per_early got %b want 0", test_busy); end
    @(posedge clk); #1;
    n_vec++; if (test_busy !== 1'b1) begin n_err++; $display("FAIL per_start got %b want 1", test_busy); end
    c = 0;
    while (!test_done && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    n_vec++; if (map_valid !== 1'b1 || fault_map !== 16'h0000) begin n_err++; $display("FAIL per_map1 got %h/%b want 0000/1", fault_map, map_valid); end
    pe5_fail_v2 = 1'b1;
    c = 0;
    while (!test_busy && c < 40) begin @(negedge clk); c++; end
    c = 0;
    while (!test_done && c < 100) begin
      n_vec++; if (map_valid !== 1'b1 || fault_map !== 16'h0000) begin n_err++; $display("FAIL per_hold got %h/%b want 0000/1", fault_map, map_valid); end
      @(negedge clk); c++;
    end
    @(negedge clk);
    pe5_fail_v2 = 1'b0;
    n_vec++; if (map_valid !== 1'b1 || fault_map !== 16'h0020) begin n_err++; $display("FAIL per_map2 got %h/%b want 0020/1", fault_map, map_valid); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef STW_PERIODIC_EN
    test_periodic();
`else
    test_all_pass();
    test_pe5_v2();
    test_timeout();
    test_back_to_back();
    test_reset_midtest();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stw_controller.md
Name: stw_controller

Overview:
- Array-level initiator for the per-PE self-test-and-write (STW) interface.
- On request, broadcasts a fixed set of MAC test vectors to every PE, pulses start, and collects each PE's complete/result handshake.
- Accumulates a sticky per-PE fault map for the system FSM and repair logic.
- Sits beside the systolic array; one instance drives all PEs in parallel.

Parameters:
- WORD_SIZE, 16, operand/result width; must match the PEs.
- NUM_PE, 16, number of PEs driven; bit i of the vector ports corresponds to PE i.
- TIMEOUT, 64, maximum WAIT cycles per vector before non-completing PEs are flagged faulty.
- TEST_PERIOD, 4096, idle cycles between automatic retests; used only with STW_PERIODIC_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- test_req  in  1  single-cycle request to start a full test; accepted only in IDLE.
- test_busy  out  1  high from acceptance until the DONE cycle inclusive.
- test_done  out  1  one-cycle pulse in DONE.
- fault_map  out  NUM_PE  1 = PE failed at least one vector or timed out.
- map_valid  out  1  fault_map holds a completed result.
- STW_test_load_en  out  1  one-cycle pulse that loads the operand buses into all PEs.
- STW_mult_op1  out  WORD_SIZE  multiplier operand 1.
- STW_mult_op2  out  WORD_SIZE  multiplier operand 2.
- STW_add_op  out  WORD_SIZE  addend.
- STW_expected  out  WORD_SIZE  expected result.
- STW_start  out  1  one-cycle start pulse.
- STW_complete  in  NUM_PE  per-PE ready/complete.
- STW_result_out  in  NUM_PE  per-PE pass (1) / fail (0); valid while complete is high.

Behaviour:
- Reset: all outputs 0. State IDLE, vec_idx 0, wait counter 0, fail accumulator 0.
- Reset mid-test aborts immediately. No partial map is published; map_valid stays 0.
- IDLE:
  - test_req=1: clear the fail accumulator, vec_idx<=0, map_valid<=0, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD (1 cycle):
  - STW_test_load_en=1; operand buses driven from vector[vec_idx].
  - Operand buses are registered and hold their value until the next LOAD.
  - Go to ARM.
- ARM (1 cycle): STW_start=1; wait counter<=0; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Exit to CHECK when counter>=1 and &STW_complete. The first WAIT cycle is ignored because PEs lower complete after start.
  - Also exit to CHECK when counter==TIMEOUT-1.
- CHECK (1 cycle):
  - fail_acc <= fail_acc | ~(STW_complete & STW_result_out). An incomplete PE is therefore faulty.
  - If vec_idx==NUM_VECTORS-1, go to DONE; else vec_idx++ and go to LOAD.
- DONE (1 cycle): fault_map<=fail_acc, map_valid<=1, test_done=1, then go to IDLE.
- test_busy = (state != IDLE).
- test_req while busy is ignored; it is not queued.
- fault_map holds its value until the next DONE.
- Fault-free latency from test_req to test_done is NUM_VECTORS*5+1 cycles: LOAD, ARM, 2 WAIT, CHECK per vector, plus DONE.
- Worst case is NUM_VECTORS*(TIMEOUT+3)+1 cycles.
- Vector arithmetic: expected = (op1*op2 + add) mod 2^WORD_SIZE, unsigned.

Optional Feature:
- Macro: STW_PERIODIC_EN.
- Defined:
  - An idle counter runs in IDLE and resets to 0 on leaving IDLE.
  - Reaching TEST_PERIOD-1 acts as an internal test_req.
  - An external test_req in the same cycle is a single request.
  - map_valid is not cleared on a periodic launch; the previous fault_map stays readable until DONE overwrites it.
- Undefined: tests start only from test_req; no idle counter exists.

Decomposition:
- Package stw_pkg holds:
  - State encoding: IDLE, LOAD, ARM, WAIT, CHECK, DONE.
  - NUM_VECTORS=4.
  - Vector constants (16-bit):
    - V0: op1=0x0003, op2=0x0005, add=0x0007, expected=0x0016.
    - V1: op1=0x00FF, op2=0x0101, add=0x0001, expected=0x0000.
    - V2: op1=0x5555, op2=0x0002, add=0xAAAA, expected=0x5554.
    - V3: op1=0x0000, op2=0x1234, add=0x8000, expected=0x8000.
- One sub-module: stw_vector_rom, a combinational lookup of vec_idx to the {op1, op2, add, expected} tuple.

Test Plan:
- All PEs pass: responder models drop complete 1 cycle after start, raise it 2 cycles later with result 1, on test_req → test_busy high; per vector load_en pulse then start pulse; V0 buses carry 3/5/7/0x16; test_done pulses; fault_map=0x0000; map_valid=1.
- PE 5 returns result 0 on V2 only → fault_map=0x0020; all 4 vectors still issued.
- PE 0 never re-asserts complete after start → each vector exits WAIT at counter 63; fault_map=0x0001; test_done occurs 4*(64+3)+1 cycles after the request.
- test_req re-pulsed during WAIT → ignored; exactly one test_done pulse; vector sequence unchanged.
- rst asserted in WAIT of V1 → all outputs 0 asynchronously; after release, a new test_req runs cleanly from V0.
- STW_PERIODIC_EN, TEST_PERIOD=16, no external request → test self-starts 16 cycles after reset exit; previous map_valid/fault_map stay stable until the new DONE.
